decoder_2to4_hold: RTL and testbench

Registered 2-to-4 one-hot decoder with a valid/ready input handshake, a minimum output hold time and an acknowledged output. It sits on the consumer side of the 4-to-2 one-hot encoder path. It turns a 2-bit code back into a one-hot line that is held stable long enough for slow downstream logic (LEDs, strobes) to sample it. It also flags input-side handshake violations.

---
 rtl/decoder_2to4_hold.sv | 127 ++++++++++++
 tb/tb_decoder_2to4_hold.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_2to4_hold.sv
// Registered 2-to-4 one-hot decoder with valid/ready input, minimum output hold and acknowledge.
// Optional accepted-code counter enabled by defining DECODER_COUNT_EN.
module decoder_2to4_hold #(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [1:0]       in_code,
    output logic             in_ready,
    output logic [3:0]       out,
    output logic             out_valid,
    input  logic             out_ack,
    input  logic             err_clr,
    output logic             error,
    output logic [CNT_W-1:0] count
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StHold = 2'd1,
        StWait = 2'd2
    } state_t;

    localparam logic [7:0] HoldLoad = 8'(HOLD_CYCLES - 1);

    state_t     state_q;
    logic [7:0] hold_cnt_q;
    logic [3:0] out_q;
    logic       out_valid_q;
    logic       in_ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            hold_cnt_q  <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        out_q       <= 4'b0001 << in_code;
                        out_valid_q <= 1'b1;
                        hold_cnt_q  <= HoldLoad;
                        in_ready_q  <= 1'b0;
                        state_q     <= StHold;
                    end
                end
                StHold: begin
                    // out_ack is deliberately not sampled here
                    if (hold_cnt_q == 8'd0) begin
                        state_q <= StWait;
                    end else begin
                        hold_cnt_q <= hold_cnt_q - 8'd1;
                    end
                end
                StWait: begin
                    if (out_ack) begin
                        out_q       <= '0;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    out_q       <= '0;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= StIdle;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out       = out_q;
    assign out_valid = out_valid_q;

    // A stalled producer must keep in_valid high and in_code steady until accepted.
    logic       prev_valid_q;
    logic       prev_ready_q;
    logic [1:0] prev_code_q;
    logic       error_q;
    logic       violation;

    assign violation = prev_valid_q && !prev_ready_q && (!in_valid || (in_code != prev_code_q));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_valid_q <= 1'b0;
            prev_ready_q <= 1'b1;
            prev_code_q  <= '0;
            error_q      <= 1'b0;
        end else begin
            prev_valid_q <= in_valid;
            prev_ready_q <= in_ready_q;
            prev_code_q  <= in_code;
            if (violation) begin
                error_q <= 1'b1;
            end else if (err_clr) begin
                error_q <= 1'b0;
            end
        end
    end

    assign error = error_q;

`ifdef DECODER_COUNT_EN
    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (in_ready_q && in_valid && (count_q != {CNT_W{1'b1}})) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;
`else
    assign count = '0;
`endif

endmodule

// File: tb/tb_decoder_2to4_hold.sv
// Directed self-checking bench for decoder_2to4_hold (HOLD_CYCLES=4).
// Expected count follows DECODER_COUNT_EN.
module tb_decoder_2to4_hold;

    localparam int unsigned HoldCycles = 4;
    localparam int unsigned CntW       = 8;
`ifdef DECODER_COUNT_EN
    localparam bit CountEn = 1'b1;
`else
    localparam bit CountEn = 1'b0;
`endif

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic [1:0]      in_code;
    logic            in_ready;
    logic [3:0]      out;
    logic            out_valid;
    logic            out_ack;
    logic            err_clr;
    logic            error;
    logic [CntW-1:0] count;

    int vectors;
    int miscompares;

    decoder_2to4_hold #(
        .HOLD_CYCLES(HoldCycles),
        .CNT_W      (CntW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_code  (in_code),
        .in_ready (in_ready),
        .out      (out),
        .out_valid(out_valid),
        .out_ack  (out_ack),
        .err_clr  (err_clr),
        .error    (error),
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_count(input int n);
        return CountEn ? 32'(n) : 32'd0;
    endfunction

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b1;
        in_code     = 2'd1;
        out_ack     = 1'b0;
        err_clr     = 1'b0;

        // Reset, with in_valid high to show it is ignored.
        tick();
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out", 32'(out), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        tick();

        // Single code 2 with out_ack tied high: out_valid for exactly 5 cycles.
        out_ack  = 1'b1;
        in_valid = 1'b1;
        in_code  = 2'd2;
        tick();
        in_valid = 1'b0;
        chk("t1_in_ready_busy", 32'(in_ready), 32'd0);
        for (int i = 0; i < 5; i++) begin
            chk("t1_out", 32'(out), 32'h4);
            chk("t1_out_valid", 32'(out_valid), 32'd1);
            tick();
        end
        chk("t1_out_idle", 32'(out), 32'h0);
        chk("t1_out_valid_idle", 32'(out_valid), 32'd0);
        chk("t1_in_ready_idle", 32'(in_ready), 32'd1);
        chk("t1_count", 32'(count), exp_count(1));

        // Back-to-back sweep of all codes, accepts 6 cycles apart.
        for (int c = 0; c < 4; c++) begin
            in_valid = 1'b1;
            in_code  = 2'(c);
            tick();
            in_valid = 1'b0;
            chk("t2_out", 32'(out), 32'h1 << c);
            chk("t2_out_valid", 32'(out_valid), 32'd1);
            tick();
            tick();
            tick();
            tick();
            chk("t2_in_ready_wait", 32'(in_ready), 32'd0);
            tick();
            chk("t2_in_ready_back", 32'(in_ready), 32'd1);
        end
        chk("t2_error", 32'(error), 32'd0);
        chk("t2_count", 32'(count), exp_count(5));

        // Code 3 held in WAIT for 20 cycles without acknowledge.
        out_ack  = 1'b0;
        in_valid = 1'b1;
        in_code  = 2'd3;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            chk("t3_out_hold", 32'(out), 32'h8);
            tick();
        end
        chk("t3_out_valid_wait", 32'(out_valid), 32'd1);
        out_ack = 1'b1;
        tick();
        out_ack = 1'b0;
        chk("t3_out_idle", 32'(out), 32'h0);
        chk("t3_in_ready", 32'(in_ready), 32'd1);

        // Acknowledge pulsed during HOLD is ignored.
        in_valid = 1'b1;
        in_code  = 2'd1;
        tick();
        in_valid = 1'b0;
        tick();
        out_ack = 1'b1;
        tick();
        out_ack = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("t4_out_valid", 32'(out_valid), 32'd1);
        chk("t4_out", 32'(out), 32'h2);
        chk("t4_in_ready", 32'(in_ready), 32'd0);
        out_ack = 1'b1;
        tick();
        out_ack = 1'b0;
        chk("t4_in_ready_idle", 32'(in_ready), 32'd1);

        // Handshake violation: code changes while stalled.
        in_valid = 1'b1;
        in_code  = 2'd0;
        tick();
        in_code = 2'd1;
        tick();
        in_code = 2'd2;
        chk("t5_error_before", 32'(error), 32'd0);
        tick();
        chk("t5_error_set", 32'(error), 32'd1);
        tick();
        tick();
        chk("t5_error_sticky", 32'(error), 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("t5_error_clr", 32'(error), 32'd0);
        err_clr = 1'b1;
        in_code = 2'd3;
        tick();
        err_clr = 1'b0;
        chk("t5_set_wins", 32'(error), 32'd1);

        // Return to IDLE, accept code 3 again, then reset asynchronously mid-HOLD.
        out_ack = 1'b1;
        tick();
        out_ack = 1'b0;
        tick();
        in_valid = 1'b0;
        chk("t6_out_pre", 32'(out), 32'h8);
        chk("t6_count_pre", 32'(count), exp_count(9));
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_out", 32'(out), 32'h0);
        chk("t6_async_out_valid", 32'(out_valid), 32'd0);
        chk("t6_async_in_ready", 32'(in_ready), 32'd1);
        chk("t6_async_count", 32'(count), 32'd0);
        chk("t6_async_error", 32'(error), 32'd0);
        in_valid = 1'b1;
        in_code  = 2'd2;
        tick();
        tick();
        chk("t6_rst_ignores_valid", 32'(out), 32'h0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        tick();
        out_ack  = 1'b1;
        in_valid = 1'b1;
        in_code  = 2'd1;
        tick();
        in_valid = 1'b0;
        chk("t6_after_out", 32'(out), 32'h2);
        chk("t6_after_count", 32'(count), exp_count(1));
        for (int i = 0; i < 5; i++) tick();
        chk("t6_after_idle", 32'(in_ready), 32'd1);
        chk("t6_after_error", 32'(error), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
